hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Multi-cycle sequencer for the HI/LO register pair in the EX stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode and runs the multiply wait or the 32-step restoring divide. Holds the pipeline stall while it runs, then issues one write (hilo_we, hi_o, lo_o) to the HI/LO register. Supports cancellation on pipeline flush.

Parameters:
MUL_CYCLES, 2, cycles spent in MUL state (models pipelined multiplier latency, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  op request, sampled when state is IDLE or DONE
op  in  4  0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MTHI, 0101 MTLO (1000-1011 see Optional Feature); others ignored
a  in  32  rs operand / MTHI-MTLO source
b  in  32  rt operand
hi_cur  in  32  current HI register value
lo_cur  in  32  current LO register value
flush  in  1  abort the in-flight op
busy  out  1  stall request to pipeline
hilo_we  out  1  HI/LO write enable, one-cycle pulse
hi_o  out  32  HI write data
lo_o  out  32  LO write data

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, counter=0, busy=0, hilo_we=0, hi_o=0, lo_o=0, all internal operand and result registers 0. Reset wins over start and flush. Reset mid-operation discards the op with no write.
- States: IDLE, MUL, DIV, DONE. busy=1 in MUL and DIV only. hilo_we = (state==DONE) & !flush.
- Start accepted at edge T in IDLE or DONE. a, b, hi_cur, lo_cur and op are latched at T. start is ignored in MUL/DIV, and ignored when op is illegal.
- MTHI: hi_o=a, lo_o=lo_cur. MTLO: hi_o=hi_cur, lo_o=a. Go to DONE at T+1. Latency 1.
- MULT/MULTU: form the 64-bit signed or unsigned product at T. Stay in MUL for MUL_CYCLES cycles (counter down to 0). DONE at T+MUL_CYCLES+1. Output hi_o=prod[63:32], lo_o=prod[31:0].
- DIV/DIVU with b==0: DONE at T+1, hi_o=a, lo_o=32'hFFFFFFFF.
- DIV/DIVU with b!=0:
  - Signed DIV takes absolute values first.
  - Run 32 restoring iterations in DIV, one quotient bit per cycle, MSB first. DONE at T+33.
  - Signed correction in the final step: quotient negated if the operand signs differ; remainder takes the sign of a.
  - Output lo_o=quotient, hi_o=remainder.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DONE lasts exactly one cycle, then IDLE unless a new start is accepted that same cycle.
- hi_o and lo_o hold their last value outside DONE.
- flush:
  - In MUL or DIV: go to IDLE next edge, no write.
  - In DONE: suppresses hilo_we.
  - flush together with start in IDLE/DONE: start is ignored.
- Back-to-back: start in the DONE cycle launches the next op. busy rises on the following cycle.

Optional Feature:
Macro HILO_MADD_EN.
- Defined: op 1000 MADD, 1001 MADDU, 1010 MSUB, 1011 MSUBU are legal. They follow MUL timing with result = {hi_cur,lo_cur} ± product (64-bit, wrap modulo 2^64). hi_cur/lo_cur are those latched at T.
- Undefined: these codes are illegal and start is ignored.

Test Plan:
- Reset then MULT a=0xFFFFFFFD (-3), b=5: busy=1 for 2 cycles, hilo_we at T+3 with hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. MULTU with the same operands: hi_o=0x00000004, lo_o=0xFFFFFFF1.
- DIVU a=100, b=7: busy=1 for 32 cycles, hilo_we at T+33, lo_o=0x0000000E, hi_o=0x00000002. DIV a=-7, b=2: lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF: lo_o=0x80000000, hi_o=0. DIVU a=5, b=0: hilo_we at T+1, hi_o=5, lo_o=0xFFFFFFFF.
- MTHI a=0x12345678, lo_cur=0xAAAA5555: hilo_we at T+1, hi_o=0x12345678, lo_o=0xAAAA5555. A second start during DONE issues a second pulse exactly 1 cycle later.
- DIV started, flush at T+10: busy drops at T+11, no hilo_we pulse ever. start during MUL is ignored (no extra write). rst at T+5 of a DIV: all outputs 0 the next cycle.
- With HILO_MADD_EN, MSUBU a=2, b=3, hi_cur=0, lo_cur=5: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFF. Without the macro, op 1010 is ignored: busy and hilo_we stay 0.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: multi-cycle MULT/DIV, one-cycle MTHI/MTLO,
// stall while busy, single-cycle HI/LO write. Define HILO_MADD_EN for MADD/MSUB.
module hilo_muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  input  logic        flush,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [63:0] prod;
  logic [31:0] dvs, quo, rem;
  logic        neg_q, neg_r;

  logic        is_mul, is_div, is_mt, legal, sgn;
  logic [63:0] mul_full, mul_res;
  logic [31:0] a_abs, b_abs;
  logic [32:0] shifted;
  logic        borrow;
  logic [31:0] q_next, r_next, q_fin, r_fin;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    is_mt  = 1'b0;
    case (op)
      4'b0000, 4'b0001: is_mul = 1'b1;
      4'b0010, 4'b0011: is_div = 1'b1;
      4'b0100, 4'b0101: is_mt  = 1'b1;
`ifdef HILO_MADD_EN
      4'b1000, 4'b1001, 4'b1010, 4'b1011: is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign legal = is_mul | is_div | is_mt;
  // Even codes within each group are the signed variants.
  assign sgn   = ~op[0];

  // Sign-extended 64x64 product truncated to 64 bits equals the signed product.
  assign mul_full = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
`ifdef HILO_MADD_EN
  assign mul_res = !op[3] ? mul_full :
                   op[1]  ? {hi_cur, lo_cur} - mul_full : {hi_cur, lo_cur} + mul_full;
`else
  assign mul_res = mul_full;
`endif

  assign a_abs = (sgn & a[31]) ? -a : a;
  assign b_abs = (sgn & b[31]) ? -b : b;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted = {rem, quo[31]};
  assign borrow  = shifted < {1'b0, dvs};
  assign q_next  = {quo[30:0], ~borrow};
  assign r_next  = borrow ? shifted[31:0] : shifted[31:0] - dvs;
  assign q_fin   = neg_q ? -q_next : q_next;
  assign r_fin   = neg_r ? -r_next : r_next;

  assign busy    = (state == S_MUL) || (state == S_DIV);
  assign hilo_we = (state == S_DONE) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      prod  <= '0;
      dvs   <= '0;
      quo   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start && !flush && legal) begin
            if (is_mt) begin
              hi_o  <= op[0] ? hi_cur : a;
              lo_o  <= op[0] ? a : lo_cur;
              state <= S_DONE;
            end else if (is_mul) begin
              prod  <= mul_res;
              count <= 6'(MUL_CYCLES - 1);
              state <= S_MUL;
            end else if (b == 32'd0) begin
              hi_o  <= a;
              lo_o  <= 32'hFFFF_FFFF;
              state <= S_DONE;
            end else begin
              dvs   <= b_abs;
              quo   <= a_abs;
              rem   <= '0;
              neg_q <= sgn & (a[31] ^ b[31]);
              neg_r <= sgn & a[31];
              count <= 6'd31;
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (flush) state <= S_IDLE;
          else if (count == 6'd0) begin
            hi_o  <= prod[63:32];
            lo_o  <= prod[31:0];
            state <= S_DONE;
          end else count <= count - 6'd1;
        end
        S_DIV: begin
          if (flush) state <= S_IDLE;
          else begin
            quo <= q_next;
            rem <= r_next;
            if (count == 6'd0) begin
              hi_o  <= r_fin;
              lo_o  <= q_fin;
              state <= S_DONE;
            end else count <= count - 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed vector bench for hilo_muldiv_ctrl: latency, busy length and HI/LO
// results per op, plus hand sequences for flush, reset and back-to-back starts.
module tb_hilo_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0, hi_cur = '0, lo_cur = '0;
  logic        flush = 1'b0;
  logic        busy, hilo_we;
  logic [31:0] hi_o, lo_o;

  int nvec = 0;
  int nmis = 0;

  hilo_muldiv_ctrl #(.MUL_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_cur(hi_cur), .lo_cur(lo_cur), .flush(flush),
    .busy(busy), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, hc, lc;
    int          lat;
    logic [31:0] eh, el;
  } vec_t;

  vec_t vt[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic no_pulse(input string name, input int n);
    int seen = 0;
    repeat (n) begin
      if (hilo_we) seen++;
      tick();
    end
    chk(name, seen, 0);
  endtask

  task automatic launch(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] hc, input logic [31:0] lc);
    start = 1'b1; op = o; a = va; b = vb; hi_cur = hc; lo_cur = lc;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, bcnt;
    launch(v.op, v.a, v.b, v.hc, v.lc);
    tick();
    // Scramble inputs after T so only latched values can produce the result.
    start = 1'b0; a = $urandom; b = $urandom; hi_cur = $urandom; lo_cur = $urandom;
    lat = 1; bcnt = 0;
    while (!hilo_we && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " busy cycles"}, bcnt, v.lat - 1);
    chk({v.name, " busy in DONE"}, busy, 0);
    chk({v.name, " hi_o"}, hi_o, v.eh);
    chk({v.name, " lo_o"}, lo_o, v.el);
    tick();
    chk({v.name, " pulse width"}, hilo_we, 0);
  endtask

  initial begin
    vt.push_back('{"MULT -3*5",    4'b0000, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 3, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vt.push_back('{"MULTU",        4'b0001, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 3, 32'h00000004, 32'hFFFFFFF1});
    vt.push_back('{"MULT min*min", 4'b0000, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 3, 32'h40000000, 32'h0});
    vt.push_back('{"MULTU max",    4'b0001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 3, 32'hFFFFFFFE, 32'h00000001});
    vt.push_back('{"DIVU 100/7",   4'b0011, 32'd100, 32'd7, 32'h0, 32'h0, 33, 32'h00000002, 32'h0000000E});
    vt.push_back('{"DIV -7/2",     4'b0010, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vt.push_back('{"DIV 7/-2",     4'b0010, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 33, 32'h00000001, 32'hFFFFFFFD});
    vt.push_back('{"DIV min/-1",   4'b0010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 33, 32'h0, 32'h80000000});
    vt.push_back('{"DIVU max/1",   4'b0011, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 33, 32'h0, 32'hFFFFFFFF});
    vt.push_back('{"DIVU /16",     4'b0011, 32'h12345678, 32'h10, 32'h0, 32'h0, 33, 32'h00000008, 32'h01234567});
    vt.push_back('{"DIVU 5/0",     4'b0011, 32'd5, 32'd0, 32'h0, 32'h0, 1, 32'h00000005, 32'hFFFFFFFF});
    vt.push_back('{"DIV -5/0",     4'b0010, 32'hFFFFFFFB, 32'd0, 32'h0, 32'h0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF});
    vt.push_back('{"MTHI",         4'b0100, 32'h12345678, 32'h0, 32'h99, 32'hAAAA5555, 1, 32'h12345678, 32'hAAAA5555});
    vt.push_back('{"MTLO",         4'b0101, 32'hCAFEF00D, 32'h0, 32'h11112222, 32'h77, 1, 32'h11112222, 32'hCAFEF00D});
`ifdef HILO_MADD_EN
    vt.push_back('{"MSUBU",        4'b1011, 32'd2, 32'd3, 32'h0, 32'd5, 3, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vt.push_back('{"MSUB",         4'b1010, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 3, 32'h0, 32'h00000006});
    vt.push_back('{"MADDU carry",  4'b1001, 32'hFFFFFFFF, 32'd2, 32'h1, 32'h2, 3, 32'h00000003, 32'h00000000});
`endif

    tick();
    tick();
    chk("reset busy", busy, 0);
    chk("reset hilo_we", hilo_we, 0);
    chk("reset hi_o", hi_o, 0);
    chk("reset lo_o", lo_o, 0);
    rst = 1'b0;
    tick();

    foreach (vt[i]) run_vec(vt[i]);

    // Back-to-back MTHI then MTLO started in the DONE cycle.
    launch(4'b0100, 32'h12345678, 32'h0, 32'h0, 32'hAAAA5555);
    tick();
    chk("b2b first we", hilo_we, 1);
    chk("b2b first hi", hi_o, 32'h12345678);
    launch(4'b0101, 32'h0BADBEEF, 32'h0, 32'h00000055, 32'h0);
    tick();
    start = 1'b0;
    chk("b2b second we", hilo_we, 1);
    chk("b2b second hi", hi_o, 32'h00000055);
    chk("b2b second lo", lo_o, 32'h0BADBEEF);
    tick();
    chk("b2b end we", hilo_we, 0);

    // Flush during DONE suppresses the write.
    launch(4'b0100, 32'h1, 32'h0, 32'h0, 32'h0);
    tick();
    start = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush in DONE we", hilo_we, 0);
    tick();
    flush = 1'b0;

    // Start during MUL is ignored: exactly one pulse with the product.
    begin
      int pulses = 0;
      logic [31:0] ph = '0, pl = '0;
      launch(4'b0000, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0);
      tick();
      launch(4'b0100, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
      tick();
      start = 1'b0;
      repeat (8) begin
        if (hilo_we) begin pulses++; ph = hi_o; pl = lo_o; end
        tick();
      end
      chk("start in MUL pulses", pulses, 1);
      chk("start in MUL hi", ph, 32'hFFFFFFFF);
      chk("start in MUL lo", pl, 32'hFFFFFFF1);
    end

    // DIV flushed at T+10.
    launch(4'b0010, 32'd1000, 32'd3, 32'h0, 32'h0);
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("div busy at T+10", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("div busy after flush", busy, 0);
    no_pulse("div flush no write", 40);

    // Illegal op (or MSUB without the feature) and an undefined code.
`ifndef HILO_MADD_EN
    launch(4'b1010, 32'd2, 32'd3, 32'h0, 32'd5);
    tick();
    start = 1'b0;
    chk("op 1010 busy", busy, 0);
    no_pulse("op 1010 no write", 5);
`endif
    launch(4'b0110, 32'd2, 32'd3, 32'h0, 32'd5);
    tick();
    start = 1'b0;
    chk("op 0110 busy", busy, 0);
    no_pulse("op 0110 no write", 5);

    // Reset at T+5 of a DIV clears everything and discards the op.
    launch(4'b0011, 32'd100, 32'd7, 32'h0, 32'h0);
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rst mid busy", busy, 0);
    chk("rst mid we", hilo_we, 0);
    chk("rst mid hi", hi_o, 0);
    chk("rst mid lo", lo_o, 0);
    rst = 1'b0;
    no_pulse("rst mid no write", 40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
